// File: rtl/error_stats_collector_pkg.sv
// Shared definitions for the error-statistics block and its neighbouring
// datapath stages: default sample width, samples per run, the derived
// sum-of-squares width and the run-control FSM state encoding.
package error_stats_collector_pkg;

    localparam int DEF_DATA_W    = 20;
    localparam int DEF_N_SAMPLES = 150;
    localparam int CNT_W         = 8;

    // Squares are 2*data_w bits wide; 8 extra bits hold up to 255 of them
    // without saturating.
    function automatic int sse_width(input int data_w);
        return 2 * data_w + 8;
    endfunction

    localparam int DEF_SSE_W = sse_width(DEF_DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/error_stats_collector_abs_square.sv
// abs_square: combinational magnitude and square of a two's-complement sample.
//   e_in    : signed error sample, DATA_W bits
//   abs_out : unsigned |e_in|, DATA_W bits (-2^(DATA_W-1) maps to 2^(DATA_W-1))
//   sq_out  : unsigned |e_in|^2, 2*DATA_W bits
module abs_square
    import error_stats_collector_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0]   e_in,
    output logic [DATA_W-1:0]   abs_out,
    output logic [2*DATA_W-1:0] sq_out
);

    // Negating in DATA_W bits and reading the result as unsigned gives the
    // correct magnitude even for the most negative input.
    assign abs_out = e_in[DATA_W-1] ? (~e_in + DATA_W'(1)) : e_in;
    assign sq_out  = {{DATA_W{1'b0}}, abs_out} * {{DATA_W{1'b0}}, abs_out};

endmodule

// File: rtl/error_stats_collector.sv
// error_stats_collector: accumulates the sum of squared errors, the peak
// absolute error and the sample count over a run of N_SAMPLES samples.
//   clk, rst            : clock, asynchronous active-low reset
//   start               : clear statistics and (re)start a run
//   e_valid, e_in       : qualified two's-complement error sample
//   sse                 : saturating unsigned sum of squares
//   max_abs             : peak |e_in| of the run
//   sample_cnt          : samples accepted in the run
//   busy                : run in progress (ACCUM or DRAIN)
//   res_valid, res_ack  : results held stable until acknowledged
module error_stats_collector
    import error_stats_collector_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int N_SAMPLES = DEF_N_SAMPLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         e_valid,
    input  logic [DATA_W-1:0]            e_in,
    output logic [sse_width(DATA_W)-1:0] sse,
    output logic [DATA_W-1:0]            max_abs,
    output logic [CNT_W-1:0]             sample_cnt,
    output logic                         busy,
    output logic                         res_valid,
    input  logic                         res_ack
);

    localparam int               SSE_W  = sse_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES);

    state_e                state_q, state_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]     s1_abs_q, s1_abs_d;
    logic [2*DATA_W-1:0]   s1_sq_q, s1_sq_d;
    logic [SSE_W-1:0]      sse_q, sse_d;
    logic [DATA_W-1:0]     max_abs_q, max_abs_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [DATA_W-1:0]     abs_w;
    logic [2*DATA_W-1:0]   sq_w;
    logic                  run_active;
    logic                  restart;
    logic                  accept;
    logic [CNT_W-1:0]      cnt_inc;
    logic [SSE_W:0]        sse_sum;

    abs_square #(.DATA_W(DATA_W)) u_abs_square (
        .e_in    (e_in),
        .abs_out (abs_w),
        .sq_out  (sq_w)
    );

    assign run_active = (state_q == ST_ACCUM) || (state_q == ST_DRAIN);
    // start is honoured everywhere except HOLD, where results must stay put.
    assign restart    = start && ((state_q == ST_IDLE) || run_active);
    // A sample coinciding with start belongs to the aborted run.
    assign accept     = (state_q == ST_ACCUM) && e_valid && !start;
    assign cnt_inc    = cnt_q + CNT_W'(1);
    // One extra bit captures the carry that triggers saturation.
    assign sse_sum    = {1'b0, sse_q} + {{(SSE_W + 1 - 2*DATA_W){1'b0}}, s1_sq_q};

    // Run-control FSM: next state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (start)                             state_d = ST_ACCUM;
                else if (accept && cnt_inc == CNT_LAST) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (start)            state_d = ST_ACCUM;
                else if (!s1_valid_q) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: stage 1 captures |e| and |e|^2, stage 2 folds them into
    // the statistics; the counter tracks acceptance directly.
    always_comb begin
        s1_valid_d = accept;
        s1_abs_d   = s1_abs_q;
        s1_sq_d    = s1_sq_q;
        sse_d      = sse_q;
        max_abs_d  = max_abs_q;
        cnt_d      = cnt_q;

        if (accept) begin
            s1_abs_d = abs_w;
            s1_sq_d  = sq_w;
        end

        if (restart) begin
            // Dropping stage-1 validity flushes the aborted run's sample.
            s1_valid_d = 1'b0;
            sse_d      = '0;
            max_abs_d  = '0;
            cnt_d      = '0;
        end else begin
            if (s1_valid_q) begin
                sse_d = sse_sum[SSE_W] ? '1 : sse_sum[SSE_W-1:0];
                if (s1_abs_q > max_abs_q) max_abs_d = s1_abs_q;
            end
            if (accept) cnt_d = cnt_inc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: stage-1 data registers are reset along with their valid
            // flag so nothing stale can ever be observed after reset.
            state_q    <= ST_IDLE;
            s1_valid_q <= 1'b0;
            s1_abs_q   <= '0;
            s1_sq_q    <= '0;
            sse_q      <= '0;
            max_abs_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_abs_q   <= s1_abs_d;
            s1_sq_q    <= s1_sq_d;
            sse_q      <= sse_d;
            max_abs_q  <= max_abs_d;
            cnt_q      <= cnt_d;
        end
    end

    assign sse        = sse_q;
    assign max_abs    = max_abs_q;
    assign sample_cnt = cnt_q;
    assign busy       = run_active;
    assign res_valid  = (state_q == ST_HOLD);

endmodule

// File: doc/error_stats_collector.md
ERROR_STATS_COLLECTOR -- requirements
Module: error_stats_collector

Interface
REQ-001 Parameter DATA_W, default 20, SHALL set the width of each error sample.
REQ-002 Parameter N_SAMPLES, default 150, SHALL set the number of error samples per run (legal range 1..255).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be an asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit, SHALL request clearing of the statistics and the start of a run.
REQ-006 Port e_valid, input, 1 bit, SHALL qualify e_in for one cycle.
REQ-007 Port e_in, input, DATA_W bits, SHALL carry a two's-complement error sample from the error-checker stage.
REQ-008 Port sse, output, 2*DATA_W+8 bits, SHALL carry the unsigned sum of squared errors.
REQ-009 Port max_abs, output, DATA_W bits, SHALL carry the unsigned maximum |e_in| seen in the run.
REQ-010 Port sample_cnt, output, 8 bits, SHALL carry the number of samples accepted in the run.
REQ-011 Port busy, output, 1 bit, SHALL be high in the ACCUM and DRAIN states.
REQ-012 Port res_valid, output, 1 bit, SHALL be high only in the HOLD state.
REQ-013 Port res_ack, input, 1 bit, SHALL acknowledge the results.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, ACCUM, DRAIN and HOLD.
REQ-015 In IDLE, start=1 SHALL clear sse, max_abs and sample_cnt and go to ACCUM on the next edge.
REQ-016 In ACCUM, each e_valid=1 cycle SHALL be accepted and increment sample_cnt.
REQ-017 Stage 1 SHALL register |e_in| and |e_in|^2; stage 2 SHALL add the square into sse and update max_abs, giving a 2-cycle latency from sample to outputs.
REQ-018 |e_in| for the most negative input (-2^(DATA_W-1)) SHALL be 2^(DATA_W-1), represented unsigned without overflow.
REQ-019 sse SHALL saturate at all-ones and never wrap.
REQ-020 When sample_cnt reaches N_SAMPLES the FSM SHALL go to DRAIN; further e_valid pulses SHALL be ignored.
REQ-021 DRAIN SHALL last until the pipeline holds no valid data (at most 2 cycles), then go to HOLD.
REQ-022 In HOLD, sse, max_abs and sample_cnt SHALL remain stable until res_ack=1, then the FSM SHALL go to IDLE on the next edge.
REQ-023 start=1 in ACCUM or DRAIN SHALL abort the run, flush the pipeline, clear all statistics and re-enter ACCUM.
REQ-024 start in HOLD SHALL be ignored; start and res_ack together in HOLD SHALL go to IDLE only.
REQ-025 e_valid outside ACCUM SHALL be ignored; res_ack outside HOLD SHALL be ignored.
REQ-026 An accepted sample in the same cycle as start in ACCUM SHALL be discarded.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, clear both pipeline stages, and drive sse=0, max_abs=0, sample_cnt=0, busy=0 and res_valid=0, including mid-run.
REQ-028 Deassertion of rst SHALL take effect at the first clk edge after release with no further initialisation.

Structure
REQ-029 DATA_W, N_SAMPLES, the sse width and the FSM state encoding SHALL live in a shared package used by this block and its neighbouring datapath stages.
REQ-030 Absolute value and squaring SHALL be one sub-module, abs_square, instantiated once in stage 1.

Verification
REQ-031 Reset then start, 150 samples all equal to +3 -> sse=1350, max_abs=3, sample_cnt=150, res_valid high 2 cycles after the last sample plus 1 for the DRAIN exit.
REQ-032 Samples -524288 followed by 149 zeros -> max_abs=524288, sse=2^38, no overflow.
REQ-033 Start mid-run after 40 samples of 5, then 150 samples of 1 -> sse=150, max_abs=1, sample_cnt=150.
REQ-034 160 e_valid pulses of 2 in a row -> sample_cnt=150, sse=600; pulses 151 to 160 are ignored.
REQ-035 In HOLD, hold res_ack=0 for 10 cycles with start pulses -> outputs stable, res_valid=1; then res_ack=1 -> IDLE next cycle, outputs retained until the next start.
REQ-036 Assert rst=0 asynchronously (between clk edges) during ACCUM -> all outputs zero immediately, FSM in IDLE.
